// File: rtl/tx_word_sched.sv
// Transmit-side word scheduler: arbitrates sources A and B onto the single
// word serializer, then times the serialization window and guard gap.
module tx_word_sched #(
  parameter int WORD_WIDTH = 12,
  parameter int GAP_CYCLES = 4,
  parameter int PRIORITY_A = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  req_a,
  input  logic [WORD_WIDTH-1:0] word_a,
  output logic                  ack_a,
  input  logic                  req_b,
  input  logic [WORD_WIDTH-1:0] word_b,
  output logic                  ack_b,
  output logic [WORD_WIDTH-1:0] ser_word,
  output logic                  ser_load,
  output logic                  grant_b,
  output logic                  busy,
  output logic [7:0]            words_sent
);

  // The counter has to hold both the shift countdown and the gap countdown.
  localparam int CNT_MAX = (WORD_WIDTH - 2 > GAP_CYCLES) ? WORD_WIDTH - 2 : GAP_CYCLES;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SHIFT_FIRST = CW'(WORD_WIDTH - 2);
  localparam logic [CW-1:0] GAP_FIRST   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  last_b, last_b_nxt;
  logic                  win_b;
  logic                  ack_a_nxt, ack_b_nxt, load_nxt, grant_b_nxt;
  logic [WORD_WIDTH-1:0] word_nxt;
  logic [7:0]            words_nxt;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    last_b_nxt  = last_b;
    win_b       = 1'b0;
    ack_a_nxt   = 1'b0;
    ack_b_nxt   = 1'b0;
    load_nxt    = 1'b0;
    grant_b_nxt = grant_b;
    word_nxt    = ser_word;
    words_nxt   = words_sent;
    case (state)
      IDLE: begin
        if (tx_en && (req_a || req_b)) begin
          if (req_a && req_b) begin
            win_b = (PRIORITY_A != 0) ? 1'b0 : ~last_b;
          end else begin
            win_b = req_b;
          end
          state_nxt   = LOAD;
          word_nxt    = win_b ? word_b : word_a;
          ack_a_nxt   = ~win_b;
          ack_b_nxt   = win_b;
          load_nxt    = 1'b1;
          grant_b_nxt = win_b;
          last_b_nxt  = win_b;
          words_nxt   = words_sent + 8'd1;
        end
      end
      LOAD: begin
        state_nxt = SHIFT;
        cnt_nxt   = SHIFT_FIRST;
      end
      SHIFT: begin
        if (cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_FIRST;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, arbitration pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_b     <= 1'b1;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      ser_load   <= 1'b0;
      ser_word   <= '0;
      grant_b    <= 1'b0;
      busy       <= 1'b0;
      words_sent <= 8'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_b     <= last_b_nxt;
      ack_a      <= ack_a_nxt;
      ack_b      <= ack_b_nxt;
      ser_load   <= load_nxt;
      ser_word   <= word_nxt;
      grant_b    <= grant_b_nxt;
      busy       <= (state_nxt != IDLE);
      words_sent <= words_nxt;
    end
  end

endmodule

// File: tb/tb_tx_word_sched.sv
// Bench for tx_word_sched: three configurations (round-robin, fixed priority,
// zero gap) share one stimulus stream and are checked against a timeline model.
module tb_tx_word_sched;

  logic        clk;
  logic        rst;
  logic        tx_en;
  logic        req_a;
  logic [11:0] word_a;
  logic        req_b;
  logic [11:0] word_b;

  logic [2:0]  ack_a_o, ack_b_o, load_o, grant_b_o, busy_o;
  logic [11:0] ser_word_o [3];
  logic [7:0]  words_o [3];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit m_valid = 0;

  // Model: per configuration, the cycle at which the scheduler is free again.
  int       gap_p [3] = '{4, 4, 0};
  int       pri_p [3] = '{0, 1, 0};
  int       idle_from [3];
  bit       m_last_b [3];
  bit       m_ack_a [3], m_ack_b [3], m_load [3], m_gb [3], m_busy [3];
  bit [7:0]  m_words [3];
  bit [11:0] m_word [3];

  int        ld_cyc [8];
  bit        ld_gb [8];
  bit [11:0] ld_word [8];
  int        ld_idle;

  tx_word_sched #(.WORD_WIDTH(12), .GAP_CYCLES(4), .PRIORITY_A(0)) u_rr (
    .clk(clk), .rst(rst), .tx_en(tx_en),
    .req_a(req_a), .word_a(word_a), .ack_a(ack_a_o[0]),
    .req_b(req_b), .word_b(word_b), .ack_b(ack_b_o[0]),
    .ser_word(ser_word_o[0]), .ser_load(load_o[0]), .grant_b(grant_b_o[0]),
    .busy(busy_o[0]), .words_sent(words_o[0]));

  tx_word_sched #(.WORD_WIDTH(12), .GAP_CYCLES(4), .PRIORITY_A(1)) u_pa (
    .clk(clk), .rst(rst), .tx_en(tx_en),
    .req_a(req_a), .word_a(word_a), .ack_a(ack_a_o[1]),
    .req_b(req_b), .word_b(word_b), .ack_b(ack_b_o[1]),
    .ser_word(ser_word_o[1]), .ser_load(load_o[1]), .grant_b(grant_b_o[1]),
    .busy(busy_o[1]), .words_sent(words_o[1]));

  tx_word_sched #(.WORD_WIDTH(12), .GAP_CYCLES(0), .PRIORITY_A(0)) u_g0 (
    .clk(clk), .rst(rst), .tx_en(tx_en),
    .req_a(req_a), .word_a(word_a), .ack_a(ack_a_o[2]),
    .req_b(req_b), .word_b(word_b), .ack_b(ack_b_o[2]),
    .ser_word(ser_word_o[2]), .ser_load(load_o[2]), .grant_b(grant_b_o[2]),
    .busy(busy_o[2]), .words_sent(words_o[2]));

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case something stalls the main sequence.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [24:0] dutVec(input int i);
    return {ack_a_o[i], ack_b_o[i], load_o[i], grant_b_o[i], busy_o[i], words_o[i], ser_word_o[i]};
  endfunction

  function automatic logic [24:0] modelVec(input int i);
    return {m_ack_a[i], m_ack_b[i], m_load[i], m_gb[i], m_busy[i], m_words[i], m_word[i]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one cycle of inputs, then advance to the next sampling point.
  task automatic applyStimulus(input bit r, input bit en, input bit ra, input logic [11:0] wa,
                               input bit rb, input logic [11:0] wb);
    rst = r; tx_en = en; req_a = ra; word_a = wa; req_b = rb; word_b = wb;
    @(negedge clk);
  endtask

  // Hold current inputs and record the next n loads of one configuration.
  task automatic collectLoads(input int inst, input int n, input string tag);
    int got = 0;
    int budget = 40 * n + 40;
    ld_idle = 0;
    while (got < n && budget > 0) begin
      if (load_o[inst]) begin
        if (got < 8) begin
          ld_cyc[got]  = cyc;
          ld_gb[got]   = grant_b_o[inst];
          ld_word[got] = ser_word_o[inst];
        end
        got++;
      end else if (got > 0 && !busy_o[inst]) begin
        ld_idle++;
      end
      if (got < n) begin
        @(negedge clk);
        budget--;
      end
    end
    checkOutput({tag, "_load_count"}, got, n);
  endtask

  // Reference timeline: a grant at edge k keeps the block busy for WORD+GAP cycles.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        m_ack_a[i] = 0; m_ack_b[i] = 0; m_load[i] = 0;
        if (rst) begin
          m_valid      = 1;
          idle_from[i] = cyc;
          m_last_b[i]  = 1;
          m_gb[i]      = 0;
          m_words[i]   = 0;
          m_word[i]    = 0;
        end else if (idle_from[i] <= cyc - 1 && tx_en && (req_a || req_b)) begin
          bit wb;
          if (req_a && req_b) wb = (pri_p[i] != 0) ? 1'b0 : !m_last_b[i];
          else                wb = req_b;
          m_word[i]    = wb ? word_b : word_a;
          m_ack_a[i]   = !wb;
          m_ack_b[i]   = wb;
          m_load[i]    = 1;
          m_gb[i]      = wb;
          m_last_b[i]  = wb;
          m_words[i]   = m_words[i] + 8'd1;
          idle_from[i] = cyc + 12 + gap_p[i];
        end
        m_busy[i] = (cyc < idle_from[i]);
      end
    end
  end

  // Every cycle after the first reset, each configuration must match the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        for (int i = 0; i < 3; i++) begin
          checkOutput($sformatf("dut%0d_outputs", i), {7'd0, dutVec(i)}, {7'd0, modelVec(i)});
        end
      end
    end
  end

  initial begin
    int busy_cnt;
    int ackb_cnt;
    rst = 1; tx_en = 0; req_a = 0; word_a = 0; req_b = 0; word_b = 0;
    @(negedge clk);

    // Reset, then a single A request.
    applyStimulus(1, 0, 0, 12'h000, 0, 12'h000);
    applyStimulus(1, 0, 0, 12'h000, 0, 12'h000);
    checkOutput("reset_state", {7'd0, dutVec(0)}, 32'd0);
    applyStimulus(0, 1, 1, 12'hA5C, 0, 12'h000);
    checkOutput("t1_ack_b_load", {ack_a_o[0], ack_b_o[0], load_o[0]}, 3'b101);
    checkOutput("t1_ser_word", ser_word_o[0], 12'hA5C);
    checkOutput("t1_words_sent", words_o[0], 8'd1);
    busy_cnt = 0;
    for (int k = 0; k < 40 && busy_o[0]; k++) begin
      if (k == 1) checkOutput("t1_strobe_clear", {ack_a_o[0], load_o[0]}, 2'b00);
      busy_cnt++;
      applyStimulus(0, 1, 0, 12'hA5C, 0, 12'h000);
    end
    checkOutput("t1_busy_cycles", busy_cnt, 16);

    // Both sources held: round-robin alternates, fixed priority always picks A.
    applyStimulus(1, 0, 0, 12'h000, 0, 12'h000);
    applyStimulus(0, 1, 1, 12'h111, 1, 12'h222);
    collectLoads(0, 4, "rr");
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rr_grant%0d", k), ld_gb[k], k % 2);
      checkOutput($sformatf("rr_word%0d", k), ld_word[k], (k % 2) ? 12'h222 : 12'h111);
      if (k > 0) checkOutput($sformatf("rr_spacing%0d", k), ld_cyc[k] - ld_cyc[k-1], 17);
    end
    collectLoads(1, 4, "pa");
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("pa_grant%0d", k), ld_gb[k], 0);
      checkOutput($sformatf("pa_word%0d", k), ld_word[k], 12'h111);
    end

    // Zero gap: back-to-back B words, one idle cycle between them.
    applyStimulus(1, 0, 0, 12'h000, 0, 12'h000);
    applyStimulus(0, 1, 0, 12'h000, 1, 12'h333);
    collectLoads(2, 3, "gap0");
    checkOutput("gap0_spacing1", ld_cyc[1] - ld_cyc[0], 13);
    checkOutput("gap0_spacing2", ld_cyc[2] - ld_cyc[1], 13);
    checkOutput("gap0_idle_cycles", ld_idle, 2);

    // tx_en drops mid-word: word completes, B waits until tx_en returns.
    applyStimulus(1, 0, 0, 12'h000, 0, 12'h000);
    applyStimulus(0, 1, 1, 12'h5A5, 0, 12'h000);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 12'h000, 1, 12'h6B6);
    ackb_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      applyStimulus(0, 0, 0, 12'h000, 1, 12'h6B6);
      if (ack_b_o[0]) ackb_cnt++;
    end
    checkOutput("txen_no_ack_b", ackb_cnt, 0);
    checkOutput("txen_parked_idle", busy_o[0], 1'b0);
    applyStimulus(0, 1, 0, 12'h000, 1, 12'h6B6);
    checkOutput("txen_resume_ack", {ack_b_o[0], load_o[0], grant_b_o[0]}, 3'b111);
    checkOutput("txen_resume_word", ser_word_o[0], 12'h6B6);
    applyStimulus(0, 1, 0, 12'h000, 0, 12'h000);

    // Reset in the middle of shifting, then wrap the word counter.
    applyStimulus(1, 0, 0, 12'h000, 0, 12'h000);
    applyStimulus(0, 1, 1, 12'h777, 0, 12'h000);
    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 0, 12'h000, 0, 12'h000);
    applyStimulus(1, 1, 0, 12'h000, 0, 12'h000);
    checkOutput("midshift_reset", {7'd0, dutVec(0)}, 32'd0);
    applyStimulus(0, 1, 1, 12'h123, 0, 12'h000);
    collectLoads(0, 256, "wrap");
    checkOutput("wrap_words_sent", words_o[0], 8'd0);
    applyStimulus(0, 1, 0, 12'h000, 0, 12'h000);

    // Randomized traffic with occasional resets and tx_en drops.
    for (int k = 0; k < 2000; k++) begin
      applyStimulus(($urandom % 300) == 0, ($urandom % 8) != 0,
                    ($urandom % 3) != 0, 12'($urandom),
                    ($urandom % 3) != 0, 12'($urandom));
    end
    applyStimulus(0, 0, 0, 12'h000, 0, 12'h000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tx_word_sched.md
Name: tx_word_sched

Overview:
- Transmit-side scheduler that shares the single 12-bit word serializer between two word sources, A and B.
- Arbitrates between pending requests and acknowledges the winner.
- Presents the winner's word to the serializer with a one-cycle load strobe.
- Times the serialization window plus a programmable inter-word guard gap before accepting the next word.
- Sits between the word generators and the serializer in the ASK transmit chain.

Parameters:
- WORD_WIDTH, 12: bits per word; must match the serializer word size.
- GAP_CYCLES, 4: idle guard cycles after the last serialized bit; legal range 0..15.
- PRIORITY_A, 0: 0 = round-robin arbitration; 1 = fixed priority, A always wins a tie.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- tx_en, input, 1: when 0, no new grant is issued; a word already in flight completes.
- req_a, input, 1: source A has a word pending; held high until ack_a.
- word_a, input, WORD_WIDTH: source A word; stable while req_a is high.
- ack_a, output, 1: one-cycle pulse; word_a has been captured.
- req_b, input, 1: source B has a word pending; same rules as A.
- word_b, input, WORD_WIDTH: source B word.
- ack_b, output, 1: one-cycle pulse; word_b has been captured.
- ser_word, output, WORD_WIDTH: word to the serializer; held stable between loads.
- ser_load, output, 1: one-cycle load strobe to the serializer (its receive_word).
- grant_b, output, 1: source of the current or most recent word; 0 = A, 1 = B.
- busy, output, 1: high in every state except IDLE.
- words_sent, output, 8: count of loads issued; wraps 255 -> 0.

Behaviour:
- Registers and outputs:
  - All outputs are registered.
  - On rst, everything clears to 0: ack_a, ack_b, ser_load, ser_word, grant_b, busy, words_sent. State = IDLE, bit/gap counter = 0, round-robin pointer last_b = 1, so A wins the first tie.
  - rst overrides all other inputs.
  - rst mid-word aborts the schedule immediately. The serializer has no reset, so it may finish shifting its current word; this is accepted.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - If tx_en=1 and (req_a or req_b), select a winner.
    - Winner is A when only req_a is high, B when only req_b is high.
    - On a tie: A if PRIORITY_A=1, else the source not granted last (!last_b ? B : A).
  - At the next edge:
    - ser_word <= winner word, ack_<winner> <= 1, ser_load <= 1.
    - grant_b and last_b updated, words_sent += 1, state -> LOAD.
  - Otherwise stay in IDLE with all strobes 0.
- LOAD (1 cycle):
  - ser_load=1, ack=1 are visible this cycle; the serializer emits bit WORD_WIDTH-1.
  - Next state SHIFT; counter <= WORD_WIDTH-2. Strobes return to 0 next cycle.
- SHIFT (WORD_WIDTH-1 cycles):
  - Decrement counter each cycle; the serializer emits bits WORD_WIDTH-2..0.
  - At counter = 0: go to GAP with counter <= GAP_CYCLES-1 if GAP_CYCLES>0, else go to IDLE.
- GAP (GAP_CYCLES cycles):
  - Decrement counter; at 0, go to IDLE.
- req_a and req_b are ignored outside IDLE. A requester must drop req, or present a new word, in the cycle after ack; the scheduler never acks the same request twice.
- Timing:
  - Request-to-load latency: 1 cycle (req sampled in IDLE at cycle t gives ser_load high in cycle t+1).
  - Minimum load-to-load spacing: WORD_WIDTH + GAP_CYCLES + 1 cycles (17 with defaults).
- tx_en falling mid-word: the current word and its gap complete, then the block parks in IDLE. tx_en rising in IDLE with req pending gives a grant with the normal 1-cycle latency.
- The round-robin pointer updates only on a grant. With PRIORITY_A=1 the pointer is still tracked but not used.
- ser_word keeps its last value after the word completes; it changes only on a grant.

Test Plan:
1. Reset then single request: rst for 2 cycles; req_a=1, word_a=12'hA5C in IDLE at cycle t.
   - Required: ack_a=ser_load=1 in cycle t+1 only; ser_word=12'hA5C; busy high for 16 cycles (t+1..t+16); words_sent=1.
2. Simultaneous requests, round-robin: req_a and req_b held continuously with word_a=12'h111, word_b=12'h222.
   - Required: grant order A, B, A, B; ser_load pulses exactly 17 cycles apart; each ack paired with the correct ser_word.
3. Fixed priority: PRIORITY_A=1, both requests held.
   - Required: every grant goes to A; ack_b never asserts while req_a is high.
4. GAP_CYCLES=0 with back-to-back req_b.
   - Required: ser_load spacing = 13 cycles; busy drops for exactly 1 cycle between words.
5. tx_en deasserted 3 cycles after a load, req_b pending.
   - Required: current word completes through GAP; no ack_b while tx_en=0; after tx_en returns high in IDLE, ack_b arrives 1 cycle later.
6. Reset mid-SHIFT at bit 5, then wrap check.
   - Required: next cycle busy=0, words_sent=0, ser_word=0, state IDLE; after 256 grants, words_sent reads 0.
